// File: rtl/rx_eth_frame_parser_if.sv
// rx_eth_frame_parser_if
//   Bundles the GMII receive pins and the parser's result signals.
//   slave  : the frame parser (samples GMII, drives results).
//   master : the PHY-side/consumer view (drives GMII, samples results).
// Signals:
//   RX_DV, RXD[7:0], RX_ER : GMII receive data valid, data and error
//   promisc                : disable the station address filter
//   rx_mac_dst/src[47:0], rx_ethertype[15:0] : captured header fields
//   rx_payload[7:0], rx_payload_valid, rx_payload_sof : payload stream
//   rx_payload_ip, rx_payload_arp : EtherType flags for the current frame
//   rx_frame_done, rx_frame_err, rx_frame_len[LEN_W-1:0] : frame status
interface rx_eth_frame_parser_if #(
   parameter int LEN_W = 11
);
   logic             RX_DV;
   logic [7:0]       RXD;
   logic             RX_ER;
   logic             promisc;
   logic [47:0]      rx_mac_dst;
   logic [47:0]      rx_mac_src;
   logic [15:0]      rx_ethertype;
   logic [7:0]       rx_payload;
   logic             rx_payload_valid;
   logic             rx_payload_sof;
   logic             rx_payload_ip;
   logic             rx_payload_arp;
   logic             rx_frame_done;
   logic             rx_frame_err;
   logic [LEN_W-1:0] rx_frame_len;

   modport master (
      output RX_DV, RXD, RX_ER, promisc,
      input  rx_mac_dst, rx_mac_src, rx_ethertype, rx_payload,
             rx_payload_valid, rx_payload_sof, rx_payload_ip, rx_payload_arp,
             rx_frame_done, rx_frame_err, rx_frame_len
   );

   modport slave (
      input  RX_DV, RXD, RX_ER, promisc,
      output rx_mac_dst, rx_mac_src, rx_ethertype, rx_payload,
             rx_payload_valid, rx_payload_sof, rx_payload_ip, rx_payload_arp,
             rx_frame_done, rx_frame_err, rx_frame_len
   );
endinterface

// File: rtl/rx_eth_frame_parser.sv
// rx_eth_frame_parser
//   GMII receive frame parser: detects preamble/SFD, captures destination
//   MAC, source MAC and EtherType, filters on station address, streams the
//   payload with the 4-byte FCS held back, and reports per-frame status.
//   Optional CRC-32 FCS check is built when RX_FCS_CHECK_EN is defined.
// Ports:
//   RX_CLK : receive clock (only clock)
//   rst_n  : synchronous active-low reset
//   bus    : rx_eth_frame_parser_if.slave (GMII inputs, results outputs)
module rx_eth_frame_parser #(
   parameter logic [47:0] MAC_ADDR      = 48'h02_00_00_00_00_01,
   parameter int          MAX_FRAME_LEN = 1518,
   parameter int          MIN_FRAME_LEN = 64,
   parameter int          LEN_W         = 11
) (
   input  logic                  RX_CLK,
   input  logic                  rst_n,
   rx_eth_frame_parser_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DONE, S_DROP
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME_LEN);
   localparam logic [LEN_W-1:0] LEN_OVF  = LEN_W'(MAX_FRAME_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME_LEN);
   localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(13);

   state_t state_reg, state_next;

   // datapath state
   logic [LEN_W-1:0] len_reg;
   logic             promisc_reg;
   logic             er_seen_reg;
   logic             sof_pending_reg;
   logic [31:0]      hb_reg;        // holdback: [31:24] is the oldest byte
   logic [2:0]       hb_cnt_reg;

   // registered outputs
   logic [47:0]      dst_reg, dst_next;
   logic [47:0]      src_reg, src_next;
   logic [15:0]      type_reg, type_next;
   logic [7:0]       payload_reg, payload_next;
   logic             valid_reg, valid_next;
   logic             sof_reg, sof_next;
   logic             ip_reg, ip_next;
   logic             arp_reg, arp_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;
   logic [LEN_W-1:0] frame_len_reg, frame_len_next;

   logic             dv;
   logic [7:0]       rxd;
   logic             sfd;
   logic             byte_in;
   logic [LEN_W-1:0] len_inc;
   logic             overflow;
   logic             hdr_last;
   logic [15:0]      type_full;
   logic             filter_pass;
   logic             hb_full;
   logic             emit;
   logic             frame_bad;
   logic             fcs_bad;

   assign dv  = bus.RX_DV;
   assign rxd = bus.RXD;

   assign sfd       = (state_reg == S_PREAMBLE) && dv && (rxd == 8'hD5);
   assign byte_in   = ((state_reg == S_HEADER) || (state_reg == S_PAYLOAD)) && dv;
   // counter saturates at MAX+1 so the overflow length is reported exactly
   assign len_inc   = (len_reg == LEN_OVF) ? len_reg : len_reg + 1'b1;
   assign overflow  = byte_in && (len_inc > LEN_MAX);
   assign hdr_last  = (state_reg == S_HEADER) && dv && (len_reg == HDR_LAST);
   assign type_full = {type_reg[7:0], rxd};
   // dst is complete by header byte 13, so the registered value is used
   assign filter_pass = (dst_reg == MAC_ADDR) || (dst_reg == 48'hFFFF_FFFF_FFFF) || promisc_reg;
   assign hb_full   = (hb_cnt_reg == 3'd4);
   // a byte leaves the holdback only when a newer one pushes it out,
   // which keeps the final four bytes (the FCS) from ever being emitted
   assign emit      = (state_reg == S_PAYLOAD) && dv && !overflow && hb_full;

`ifdef RX_FCS_CHECK_EN
   logic [31:0] crc_reg;
   logic [31:0] crc_rev;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   // the reflected register leaves the residue bit-reversed
   for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
      assign crc_rev[gi] = crc_reg[31-gi];
   end

   always_ff @(posedge RX_CLK) begin
      if (!rst_n) begin
         crc_reg <= 32'hFFFF_FFFF;
      end else if (sfd) begin
         crc_reg <= 32'hFFFF_FFFF;
      end else if (byte_in) begin
         crc_reg <= crc32_byte(crc_reg, rxd);
      end
   end

   assign fcs_bad = (crc_rev != 32'hC704_DD7B);
`else
   assign fcs_bad = 1'b0;
`endif

   // DV falling while still in HEADER is an error by itself
   assign frame_bad = er_seen_reg || (len_reg < LEN_MIN) ||
                      (state_reg == S_HEADER) || fcs_bad;

   // state register
   always_ff @(posedge RX_CLK) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         // DONE behaves like IDLE so a preamble may start right after it
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (dv) state_next = (rxd == 8'h55) ? S_PREAMBLE : S_DROP;
         end
         S_PREAMBLE: begin
            if (!dv)                state_next = S_IDLE;
            else if (rxd == 8'h55)  state_next = S_PREAMBLE;
            else if (rxd == 8'hD5)  state_next = S_HEADER;
            else                    state_next = S_DROP;
         end
         S_HEADER: begin
            if (!dv)           state_next = S_DONE;
            else if (overflow) state_next = S_DROP;
            else if (hdr_last) state_next = filter_pass ? S_PAYLOAD : S_DROP;
         end
         S_PAYLOAD: begin
            if (!dv)           state_next = S_DONE;
            else if (overflow) state_next = S_DROP;
         end
         S_DROP: begin
            if (!dv) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // output next-value logic
   always_comb begin
      dst_next       = dst_reg;
      src_next       = src_reg;
      type_next      = type_reg;
      ip_next        = ip_reg;
      arp_next       = arp_reg;
      payload_next   = payload_reg;
      valid_next     = emit;
      sof_next       = emit && sof_pending_reg;
      done_next      = (((state_reg == S_HEADER) || (state_reg == S_PAYLOAD)) && !dv) || overflow;
      err_next       = done_next && (overflow || frame_bad);
      frame_len_next = frame_len_reg;

      if (done_next) frame_len_next = overflow ? len_inc : len_reg;
      if (emit)      payload_next   = hb_reg[31:24];

      if (sfd) begin
         ip_next  = 1'b0;
         arp_next = 1'b0;
      end

      if ((state_reg == S_HEADER) && dv) begin
         if (len_reg < LEN_W'(6))       dst_next  = {dst_reg[39:0], rxd};
         else if (len_reg < LEN_W'(12)) src_next  = {src_reg[39:0], rxd};
         else                           type_next = type_full;
      end

      if (hdr_last) begin
         ip_next  = (type_full == 16'h0800);
         arp_next = (type_full == 16'h0806);
      end
   end

   // output registers
   always_ff @(posedge RX_CLK) begin
      if (!rst_n) begin
         dst_reg       <= '0;
         src_reg       <= '0;
         type_reg      <= '0;
         payload_reg   <= '0;
         valid_reg     <= 1'b0;
         sof_reg       <= 1'b0;
         ip_reg        <= 1'b0;
         arp_reg       <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         frame_len_reg <= '0;
      end else begin
         dst_reg       <= dst_next;
         src_reg       <= src_next;
         type_reg      <= type_next;
         payload_reg   <= payload_next;
         valid_reg     <= valid_next;
         sof_reg       <= sof_next;
         ip_reg        <= ip_next;
         arp_reg       <= arp_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         frame_len_reg <= frame_len_next;
      end
   end

   // datapath: length counter, sampled flags, holdback register
   always_ff @(posedge RX_CLK) begin
      if (!rst_n) begin
         len_reg         <= '0;
         promisc_reg     <= 1'b0;
         er_seen_reg     <= 1'b0;
         sof_pending_reg <= 1'b0;
         hb_reg          <= '0;
         hb_cnt_reg      <= '0;
      end else begin
         if (sfd) begin
            len_reg         <= '0;
            promisc_reg     <= bus.promisc;
            er_seen_reg     <= 1'b0;
            sof_pending_reg <= 1'b1;
         end else if (byte_in) begin
            len_reg <= len_inc;
            if (bus.RX_ER) er_seen_reg <= 1'b1;
         end

         if (hdr_last) begin
            hb_cnt_reg <= '0;
         end else if ((state_reg == S_PAYLOAD) && dv) begin
            hb_reg <= {hb_reg[23:0], rxd};
            if (!hb_full) hb_cnt_reg <= hb_cnt_reg + 3'd1;
         end

         if (emit) sof_pending_reg <= 1'b0;
      end
   end

   assign bus.rx_mac_dst       = dst_reg;
   assign bus.rx_mac_src       = src_reg;
   assign bus.rx_ethertype     = type_reg;
   assign bus.rx_payload       = payload_reg;
   assign bus.rx_payload_valid = valid_reg;
   assign bus.rx_payload_sof   = sof_reg;
   assign bus.rx_payload_ip    = ip_reg;
   assign bus.rx_payload_arp   = arp_reg;
   assign bus.rx_frame_done    = done_reg;
   assign bus.rx_frame_err     = err_reg;
   assign bus.rx_frame_len     = frame_len_reg;

endmodule

// File: doc/rx_eth_frame_parser.md
# rx_eth_frame_parser

Parametrised GMII receive-side frame parser, the successor of the first-generation receive FSM. It sits between the GMII PHY receive pins and the IP/ARP layers. It detects preamble/SFD, captures destination/source MAC and EtherType, and filters on station address. It streams the payload with the 4-byte FCS stripped and reports per-frame status with length.

## Interface
Parameters:
- `MAC_ADDR`, 48'h02_00_00_00_00_01, station address for the unicast filter.
- `MAX_FRAME_LEN`, 1518, maximum bytes after SFD, including FCS; longer frames are dropped.
- `MIN_FRAME_LEN`, 64, minimum bytes after SFD, including FCS; shorter frames are runts.
- `LEN_W`, 11, width of the length counter and `rx_frame_len`; must hold MAX_FRAME_LEN+1.

Ports:
- `RX_CLK` in 1: GMII receive clock, the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `RX_DV` in 1: GMII data valid.
- `RXD` in 8: GMII data.
- `RX_ER` in 1: GMII receive error.
- `promisc` in 1: when high, the address filter is disabled; it is sampled at the SFD.
- `rx_mac_dst` out 48: captured destination MAC.
- `rx_mac_src` out 48: captured source MAC.
- `rx_ethertype` out 16: captured EtherType.
- `rx_payload` out 8: payload byte.
- `rx_payload_valid` out 1: `rx_payload` is valid this cycle.
- `rx_payload_sof` out 1: first payload byte, coincident with valid.
- `rx_payload_ip` out 1: the current frame has EtherType 0x0800; held for the frame.
- `rx_payload_arp` out 1: the current frame has EtherType 0x0806; held for the frame.
- `rx_frame_done` out 1: one-cycle end-of-frame strobe.
- `rx_frame_err` out 1: status qualified by `rx_frame_done`.
- `rx_frame_len` out LEN_W: bytes after SFD, including FCS, qualified by `rx_frame_done`.

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DONE, DROP.
- IDLE:
  - RX_DV=1 and RXD=8'h55 -> PREAMBLE.
  - RX_DV=1 with any other byte -> DROP.
- PREAMBLE:
  - RXD=8'h55 -> stay.
  - RXD=8'hD5 -> HEADER; clear the length counter and sample `promisc`.
  - Any other byte, or RX_DV=0 -> DROP if RX_DV=1, else IDLE. No done strobe is issued.
- HEADER: 14 bytes. Bytes 0-5 shift into `rx_mac_dst` (MSB first), bytes 6-11 into `rx_mac_src`, bytes 12-13 into `rx_ethertype`.
- End of header (byte 13): set `rx_payload_ip`/`rx_payload_arp` from the EtherType.
  - Filter pass (dst == MAC_ADDR, dst == 48'hFFFF_FFFF_FFFF, or `promisc`) -> PAYLOAD.
  - Filter fail -> DROP silently. No payload and no done strobe are issued.
- PAYLOAD: bytes enter a 4-byte holdback shift register. A byte is emitted on `rx_payload` only when a newer byte pushes it out, so the final 4 bytes (FCS) are never emitted.
- RX_DV falling in HEADER or PAYLOAD -> DONE. DONE lasts one cycle, asserts `rx_frame_done`, then goes to IDLE.
- `rx_frame_err` is set if any of these hold:
  - RX_ER was seen after the SFD.
  - Length < MIN_FRAME_LEN.
  - DV fell during HEADER.
  - FCS mismatch (only when the FCS check is compiled in; see Configuration).
- Length exceeds MAX_FRAME_LEN -> DROP immediately. A done strobe fires with err=1 and len=MAX_FRAME_LEN+1; the counter saturates.
- DROP: wait for RX_DV=0, then go to IDLE.
- Header registers and the ip/arp flags hold their values until the next SFD.
- Reset, including mid-frame: state IDLE, all outputs 0, holdback register cleared. A frame in flight is then discarded via DROP, because IDLE requires 8'h55 at DV high.

## Timing
- All outputs are registered.
- A byte sampled at edge t is emitted at edge t+4, i.e. it is valid in the cycle after t+4. This requires bytes sampled at t+1..t+4 with RX_DV=1.
- `rx_payload_valid` is contiguous while RX_DV is high, with no gaps.
- `rx_payload_sof` accompanies the first emitted byte only.
- `rx_frame_done` is registered at the first edge where RX_DV=0 is sampled, and is high for exactly one cycle.
- `rx_payload_valid` is 0 in the DONE cycle.
- A new preamble may start the cycle after DONE.
- Minimum inter-frame gap supported: 1 cycle of RX_DV=0.

## Configuration
- `RX_FCS_CHECK_EN` defined:
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over all bytes after SFD, including FCS.
  - A residue other than 0xC704DD7B sets `rx_frame_err`.
- Undefined: no CRC logic is built, and FCS bytes are stripped but not checked.

## Test plan
- 7×0x55, 0xD5, dst=MAC_ADDR, src=0x0A0B0C0D0E0F, type 0x0800, 46 payload bytes 0x00..0x2D, valid FCS:
  - 46 valid cycles carrying 0x00..0x2D, sof on 0x00, `rx_payload_ip`=1.
  - done with err=0 and len=64.
- Same frame with dst=0x0200_0000_0099 and promisc=0: no valid, no done. With promisc=1: full payload is emitted.
- Broadcast ARP frame (type 0x0806, 28-byte payload padded to 46): `rx_payload_arp`=1, done with err=0, len=64.
- Frame with the last FCS byte flipped:
  - With `RX_FCS_CHECK_EN`: done with err=1.
  - Without it: err=0.
- 20-byte frame after SFD: done with err=1, len=20. A 1600-byte frame: done with err=1 at byte 1519, then DROP until DV falls.
- Assert rst_n=0 for 2 cycles at payload byte 10, then release while DV is still high: outputs are 0, and no done until the next well-formed frame, which parses correctly.
